// File: rtl/hex_display_driver_if.sv
// ============================================================================
// hex_display_driver_if : load/data/mode bus and segment outputs | rev 1.0
// ============================================================================
`default_nettype none

interface hex_display_driver_if #(
  parameter int NUM_DIGITS = 6
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data;
  logic [1:0]                mode;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [7*NUM_DIGITS-1:0]   hex_seg;
  logic                      blink_phase;

  modport master (
    output load, data, mode, blink_mask,
    input  hex_seg, blink_phase
  );

  modport slave (
    input  load, data, mode, blink_mask,
    output hex_seg, blink_phase
  );
endinterface

`default_nettype wire

// File: rtl/hex_display_driver.sv
// ============================================================================
// hex_display_driver : registered 7-seg driver with LZB, blink, lamp test | rev 1.0
// ============================================================================
`default_nettype none

module hex_display_driver #(
  parameter int NUM_DIGITS        = 6,
  parameter int BLINK_HALF_PERIOD = 25000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  hex_display_driver_if.slave    bus
);

  localparam int CNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [1:0]       c_MODE_HEX   = 2'd0;
  localparam logic [1:0]       c_MODE_LZB   = 2'd1;
  localparam logic [1:0]       c_MODE_BLANK = 2'd2;
  localparam logic [1:0]       c_MODE_LAMP  = 2'd3;
  localparam logic [7*NUM_DIGITS-1:0] c_SEG_BLANK =
    (ACTIVE_LOW != 0) ? {(7*NUM_DIGITS){1'b1}} : {(7*NUM_DIGITS){1'b0}};

  logic [4*NUM_DIGITS-1:0] r_data_q;
  logic [1:0]              r_mode_q;
  logic [NUM_DIGITS-1:0]   r_mask_q;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_blink_phase;
  logic [7*NUM_DIGITS-1:0] r_hex_seg;
  logic [7*NUM_DIGITS-1:0] w_seg_next;
  logic                    w_wrap;

  // Active-high segment patterns, bit 0 = segment a
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h7C;
      4'hC: f_decode = 7'h39;
      4'hD: f_decode = 7'h5E;
      4'hE: f_decode = 7'h79;
      default: f_decode = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q <= '0;
      r_mode_q <= c_MODE_HEX;
      r_mask_q <= '0;
    end else if (bus.load) begin
      r_data_q <= bus.data;
      r_mode_q <= bus.mode;
      r_mask_q <= bus.blink_mask;
    end
  end

  assign w_wrap = (r_cnt == c_CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt         <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic       w_upper_nz;
    logic       w_lz_blank;
    logic       w_blink_off;
    logic [6:0] w_code;

    // A digit is a leading zero when it and every digit above it are zero
    assign w_upper_nz  = |r_data_q[4*NUM_DIGITS-1 : 4*gi];
    assign w_lz_blank  = (gi != 0) && !w_upper_nz && (r_mode_q == c_MODE_LZB);
    assign w_blink_off = r_mask_q[gi] && r_blink_phase;

    always_comb begin
      case (r_mode_q)
        c_MODE_BLANK: w_code = 7'h00;
        c_MODE_LAMP:  w_code = 7'h7F;
        default:      w_code = (w_lz_blank || w_blink_off) ? 7'h00
                                                           : f_decode(r_data_q[4*gi +: 4]);
      endcase
    end

    assign w_seg_next[7*gi +: 7] = (ACTIVE_LOW != 0) ? ~w_code : w_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex_seg <= c_SEG_BLANK;
    end else begin
      r_hex_seg <= w_seg_next;
    end
  end

  assign bus.hex_seg     = r_hex_seg;
  assign bus.blink_phase = r_blink_phase;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_driver.sv
// ============================================================================
// tb_hex_display_driver : directed + random checks against a behavioural model | rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_driver;

  localparam int ND  = 6;
  localparam int BHP = 4;
  localparam int AL  = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hex_display_driver_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_driver #(
    .NUM_DIGITS       (ND),
    .BLINK_HALF_PERIOD(BHP),
    .ACTIVE_LOW       (AL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: captured word/mode/mask and number of clock edges since reset release
  logic [4*ND-1:0] m_data;
  logic [1:0]      m_mode;
  logic [ND-1:0]   m_mask;
  int              m_edges;
  logic [7*ND-1:0] m_exp;
  logic            m_phase;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7*ND-1:0] ref_seg(input logic [4*ND-1:0] d, input logic [1:0] md,
                                              input logic [ND-1:0] mk, input logic ph);
    logic [7*ND-1:0] r;
    logic [6:0] s;
    logic [3:0] nib;
    bit seen;
    seen = 0;
    r = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = d[4*i +: 4];
      if (nib != 0) seen = 1;
      s = SEG[nib];
      if (md == 2) s = 7'h00;
      else if (md == 3) s = 7'h7F;
      else begin
        if (md == 1 && !seen && i != 0) s = 7'h00;
        if (mk[i] && ph) s = 7'h00;
      end
      r[7*i +: 7] = (AL != 0) ? ~s : s;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_mode  = 2'd0;
    m_mask  = '0;
    m_edges = 0;
    m_exp   = {(7*ND){1'b1}};
    m_phase = 1'b0;
  endtask

  // Advance one clock edge; output reflects state held before the edge
  task automatic tick();
    @(posedge clk);
    m_exp = ref_seg(m_data, m_mode, m_mask, ((m_edges / BHP) % 2) == 1);
    if (bus.load) begin
      m_data = bus.data;
      m_mode = bus.mode;
      m_mask = bus.blink_mask;
    end
    m_edges++;
    m_phase = ((m_edges / BHP) % 2) == 1;
    #1;
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (bus.hex_seg === m_exp) else begin
      n_err++;
      $error("FAIL %s: hex_seg=%h expected %h", tag, bus.hex_seg, m_exp);
    end
    n_cmp++;
    assert (bus.blink_phase === m_phase) else begin
      n_err++;
      $error("FAIL %s_phase: blink_phase=%b expected %b", tag, bus.blink_phase, m_phase);
    end
  endtask

  task automatic check_const(input string tag, input logic [7*ND-1:0] want);
    n_cmp++;
    assert (bus.hex_seg === want) else begin
      n_err++;
      $error("FAIL %s: hex_seg=%h expected %h", tag, bus.hex_seg, want);
    end
  endtask

  task automatic drive(input logic ld, input logic [4*ND-1:0] d, input logic [1:0] md,
                       input logic [ND-1:0] mk);
    bus.load       = ld;
    bus.data       = d;
    bus.mode       = md;
    bus.blink_mask = mk;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_const("reset_blank", {(7*ND){1'b1}});
    check("reset_state");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, 2'd0, '0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    tick();
    check_const("post_reset_zero", {ND{7'h40}});
    check("post_reset");

    // Hex decode, then hold after load deasserts
    drive(1'b1, 24'h00A5F3, 2'd0, 6'b0);
    tick(); check("hex_load_edge");
    drive(1'b0, 24'hFFFFFF, 2'd3, 6'h3F);
    tick(); check("hex_visible");
    check_const("hex_const", {7'h40, 7'h40, 7'h08, 7'h12, 7'h0E, 7'h30});
    for (int i = 0; i < 3; i++) begin
      tick(); check("hex_hold");
    end

    // Leading-zero blanking
    drive(1'b1, 24'h00A5F3, 2'd1, 6'b0);
    tick(); drive(1'b0, 24'h0, 2'd0, 6'b0);
    tick(); check_const("lzb_a5f3", {7'h7F, 7'h7F, 7'h08, 7'h12, 7'h0E, 7'h30});
    drive(1'b1, 24'h000000, 2'd1, 6'b0);
    tick(); drive(1'b0, 24'h0, 2'd0, 6'b0);
    tick(); check_const("lzb_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("lzb_zero_model");

    // Blink digit 0
    drive(1'b1, 24'h123456, 2'd0, 6'b000001);
    tick(); drive(1'b0, 24'h0, 2'd0, 6'b0);
    for (int i = 0; i < 16; i++) begin
      tick(); check("blink");
    end

    // Mid-blink reset when phase=1 and cnt=2
    while ((m_edges % (2 * BHP)) != (BHP + 2)) begin
      tick(); check("blink_pre_reset");
    end
    do_reset();
    for (int i = 0; i < BHP + 2; i++) begin
      tick(); check("post_reset_divider");
    end

    // Modes 2 and 3 with blink active
    drive(1'b1, 24'h89ABCD, 2'd2, 6'h3F);
    tick(); drive(1'b0, 24'h0, 2'd0, 6'b0);
    for (int i = 0; i < 2 * BHP; i++) begin
      tick(); check("mode2");
    end
    check_const("mode2_const", {ND{7'h7F}});
    drive(1'b1, 24'h89ABCD, 2'd3, 6'h3F);
    tick(); drive(1'b0, 24'h0, 2'd0, 6'b0);
    for (int i = 0; i < 2 * BHP; i++) begin
      tick(); check("mode3");
      check_const("mode3_const", {ND{7'h00}});
    end

    // Load held high, data changing every cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 24'($urandom), 2'($urandom_range(0, 1)), 6'($urandom));
      tick(); check("load_held");
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) == 0), 24'($urandom >> $urandom_range(0, 24)),
            2'($urandom), 6'($urandom));
      tick(); check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised seven-segment display driver for the board's HEX digit bank, replacing the fixed six-digit slice-and-invert mapping at top level. It captures a packed nibble word on a load strobe and decodes each nibble to segments. It also provides leading-zero blanking, per-digit blinking from an internal divider, all-blank and lamp-test modes, and selectable output polarity. It sits between the HPS-side PIO registers and the HEX pins, with registered outputs.

## Interface
- NUM_DIGITS, 6, number of digits driven (1..8)
- BLINK_HALF_PERIOD, 25000000, clock cycles per blink half-period (>=1); counter width = $clog2(BLINK_HALF_PERIOD), minimum 1
- ACTIVE_LOW, 1, 1 = segment on drives 0 (DE1-SoC HEX); 0 = segment on drives 1

- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- load  in  1  capture data, mode, blink_mask this cycle
- data  in  4*NUM_DIGITS  nibble per digit, digit 0 = data[3:0]
- mode  in  2  0 = hex, 1 = hex with leading-zero blanking, 2 = all blank, 3 = lamp test (all segments on)
- blink_mask  in  NUM_DIGITS  bit i = 1 blinks digit i
- hex_seg  out  7*NUM_DIGITS  digit i at [7i+6:7i], bit order g..a (bit0 = a)
- blink_phase  out  1  current blink phase, 1 = blinked digits dark

## Operation
- Shadow registers data_q, mode_q, mask_q load when load=1; otherwise hold. load held high tracks the inputs every cycle.
- Segment codes, active-high form:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Blank = 00 in active-high form. When ACTIVE_LOW=1, every code is inverted at the output stage: blank = 7F, "0" = 40.
- Mode 1 (leading-zero blanking):
  - Scanning from digit NUM_DIGITS-1 down, each digit with nibble 0 is blanked until the first nonzero nibble; all digits from there down are shown.
  - Digit 0 is never blanked by this rule, so an all-zero word shows a single "0".
- Mode 2: all digits blank, regardless of blink state.
- Mode 3: all segments on (active-high 7F), regardless of blink state.
- Blink applies in modes 0 and 1 only. Digit i is forced blank when mask_q[i]=1 and blink_phase=1.
- Blink divider:
  - cnt counts 0..BLINK_HALF_PERIOD-1 every cycle.
  - On the wrap cycle (cnt = BLINK_HALF_PERIOD-1), cnt returns to 0 and blink_phase toggles.
  - The divider free-runs; load does not reset or stall it.
  - With BLINK_HALF_PERIOD=1, blink_phase toggles every cycle.
- Simultaneous load and wrap: both take effect. The new mask is combined with the new phase on the following output update.

## Timing
- Reset (async assert, any time, including mid-blink or mid-load):
  - data_q = 0, mode_q = 0, mask_q = 0, cnt = 0, blink_phase = 0.
  - hex_seg = all digits blank (all ones when ACTIVE_LOW=1).
- Output register updates every clock from the shadow registers and blink_phase.
- First rising edge after reset release: hex_seg shows "0" on every digit (mode 0, data 0).
- Latency: load sampled at edge N → shadow updated at N → hex_seg reflects it at edge N+1. Two cycles from load-asserted cycle to visible output.
- blink_phase toggles at the edge where cnt wraps. The affected digits change on hex_seg one edge later.
- No combinational path from any input to hex_seg or blink_phase.

## Test plan
- Reset: assert reset asynchronously with NUM_DIGITS=6, ACTIVE_LOW=1 → hex_seg = 42'h3FF_FFFF_FFFF immediately and blink_phase=0. Release reset → after one edge every digit = 7'h40.
- Hex decode: load data=24'h00A5F3, mode=0, mask=0 → two cycles later, digits 0..5 = 30, 0E, 12, 08, 40, 40. Values hold after load deasserts.
- Leading-zero blanking, mode=1:
  - data=24'h00A5F3 → digits 5 and 4 = 7F; digits 3..0 are as in the hex decode test.
  - data=0 → only digit 0 = 40; digits 1..5 = 7F.
- Blink: BLINK_HALF_PERIOD=4, load mask=6'b000001, data=24'h123456, mode=0 → blink_phase toggles every 4 cycles. Digit 0 alternates 7'h02 / 7'h7F four cycles each; digits 1..5 stay steady.
- Mid-operation reset: assert reset during blink_phase=1 with cnt=2 → outputs blank asynchronously, blink_phase=0, cnt=0. After release, the first phase toggle occurs exactly BLINK_HALF_PERIOD cycles later.
- Mode 2 vs mode 3 with blink active:
  - mode 2 → all digits 7F.
  - mode 3 → all digits 00 regardless of blink_phase.
  - load held high while data changes every cycle → hex_seg follows each value with 2-cycle latency.
